// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side burst drainer: FSM state encoding and
// the width of the lifetime pop counter.
package fifo_rd_pkg;

  localparam int RD_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer between the FIFO pop and the downstream stream.
// The caller never pushes when full nor pops when empty.
module fifo_rd_skid #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_din,
  input  logic             i_pop,
  output logic [DSIZE-1:0] o_dout,
  output logic [1:0]       o_occupancy
);

  logic [DSIZE-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout      = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a burst of burst_len words from a FIFO read port into a valid/ready
// stream. Optional running XOR of popped words: define FIFO_RD_CHECKSUM_EN.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int LWIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  input  logic                  start,
  input  logic [LWIDTH-1:0]     burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  output logic [DSIZE-1:0]      m_data,
  input  logic                  m_ready,
  output logic [RD_COUNT_W-1:0] rd_count,
  output logic [DSIZE-1:0]      checksum
);

  rd_state_e             r_state;
  rd_state_e             w_state_next;
  logic [LWIDTH-1:0]     r_remaining;
  logic [RD_COUNT_W-1:0] r_rd_count;
  logic [1:0]            w_occ;
  logic                  w_rinc;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_buf_empties;

  assign w_rinc  = (r_state == DRAIN) && !rempty && (r_remaining != '0) && (w_occ != 2'd2);
  assign m_valid = (w_occ != 2'd0);
  assign w_xfer  = m_valid && m_ready;
  // Buffer is empty after this edge: lets done follow the final transfer directly.
  assign w_buf_empties = (w_occ == 2'd0) || ((w_occ == 2'd1) && w_xfer && !w_rinc);

  fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .i_push      (w_rinc),
    .i_din       (rdata),
    .i_pop       (w_xfer),
    .o_dout      (m_data),
    .o_occupancy (w_occ)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = DRAIN;
          w_load       = 1'b1;
        end
      end
      DRAIN: begin
        if ((r_remaining == '0) || (w_rinc && (r_remaining == LWIDTH'(1))))
          w_state_next = FLUSH;
      end
      FLUSH: begin
        if (w_buf_empties) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_rd_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load)      r_remaining <= burst_len;
      else if (w_rinc) r_remaining <= r_remaining - LWIDTH'(1);
      if (w_rinc)      r_rd_count  <= r_rd_count + RD_COUNT_W'(1);
    end
  end

  assign rinc     = w_rinc;
  assign rd_count = r_rd_count;

`ifdef FIFO_RD_CHECKSUM_EN
  logic [DSIZE-1:0] r_checksum;

  // Cleared only by an accepted start, so the value holds after DONE.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)     r_checksum <= '0;
    else if (w_load) r_checksum <= '0;
    else if (w_rinc) r_checksum <= r_checksum ^ rdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter DSIZE, default 8, FIFO/stream data width in bits.
REQ-002 Parameter LWIDTH, default 8, burst_len width; maximum burst is 2^LWIDTH-1 words.
REQ-003 rclk  input  1  sole clock, rising edge.
REQ-004 rrst_n  input  1  reset, asynchronous, active-low.
REQ-005 rempty  input  1  FIFO read-side empty flag.
REQ-006 rdata  input  DSIZE  FIFO head word, valid whenever rempty=0.
REQ-007 rinc  output  1  FIFO pop strobe; one word is removed per rclk edge with rinc=1.
REQ-008 start  input  1  burst request, sampled only in IDLE.
REQ-009 burst_len  input  LWIDTH  number of words to drain, sampled with start.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 m_valid  output  1  downstream word valid.
REQ-013 m_data  output  DSIZE  downstream word.
REQ-014 m_ready  input  1  downstream accept; a transfer occurs on an edge with m_valid=1 and m_ready=1.
REQ-015 rd_count  output  16  total words popped since reset.
REQ-016 checksum  output  DSIZE  XOR of words popped in the current/last burst.

Function
REQ-017 The FSM SHALL use states IDLE, DRAIN, FLUSH, DONE.
REQ-018 IDLE: start=1 SHALL load remaining=burst_len, clear checksum and enter DRAIN; start SHALL be ignored in all other states.
REQ-019 rinc SHALL equal (state==DRAIN) & !rempty & (remaining!=0) & (occupancy<2), combinationally.
REQ-020 On an edge with rinc=1, rdata SHALL be written into a 2-entry output buffer, remaining SHALL decrement and rd_count SHALL increment.
REQ-021 m_valid SHALL equal (occupancy!=0) and m_data SHALL be the oldest buffered word; first-in order is preserved.
REQ-022 Latency: a word popped at edge N SHALL be on m_data with m_valid=1 in the cycle after N, given an empty buffer.
REQ-023 With m_ready held at 1 and the FIFO non-empty, throughput SHALL be one word per cycle.
REQ-024 A pop and a downstream transfer on the same edge SHALL leave occupancy unchanged.
REQ-025 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 rempty=1 in DRAIN SHALL stall the FSM in DRAIN with rinc=0; there is no timeout.
REQ-027 DRAIN SHALL go to FLUSH on the edge where remaining reaches 0, or immediately when burst_len=0.
REQ-028 FLUSH SHALL go to DONE when occupancy==0.
REQ-029 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-030 rd_count SHALL wrap from 65535 to 0.

Reset
REQ-031 rrst_n=0 SHALL asynchronously force IDLE, occupancy=0, remaining=0, rd_count=0 and checksum=0.
REQ-032 During reset, rinc=0, busy=0, done=0 and m_valid=0.
REQ-033 Reset mid-burst SHALL discard buffered words without popping further words.

Configuration
REQ-034 With FIFO_RD_CHECKSUM_EN defined, checksum SHALL XOR each popped word in on the pop edge, and SHALL be stable from DONE until the next accepted start.
REQ-035 Without FIFO_RD_CHECKSUM_EN, the checksum port SHALL remain present and be tied to 0, with no checksum register.

Structure
REQ-036 Package fifo_rd_pkg SHALL hold the FSM state typedef (IDLE, DRAIN, FLUSH, DONE) and the rd_count width constant (16).
REQ-037 The 2-entry buffer SHALL be the sub-module fifo_rd_skid, parameterised by DSIZE, with push/pop/occupancy ports.

Verification
REQ-038 FIFO preloaded with 0x11,0x22,0x33; start with burst_len=3; m_ready=1 -> rinc high for 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles, done 1 cycle after the last transfer, rd_count=3, checksum=0x00.
REQ-039 FIFO holds 5 words; burst_len=5; m_ready=0 for 10 cycles -> rinc pulses exactly twice and stalls; after m_ready=1, all 5 words arrive in order and done=1 once.
REQ-040 FIFO empty; start with burst_len=4; feed one word every 4 cycles -> rinc=0 while rempty=1, 4 pops total, busy=1 throughout until done.
REQ-041 start with burst_len=0 -> rinc never asserts, DRAIN->FLUSH->DONE, done pulses 3 cycles after start, rd_count unchanged.
REQ-042 rrst_n=0 mid-burst with 2 words buffered -> m_valid, rinc and busy are 0 immediately; after release a new burst_len=1 start delivers the next FIFO word.
REQ-043 rd_count forced near 65535 by running 65536 single-word bursts -> rd_count reads 0 after the 65536th pop.
